sbi_arbiter: RTL and testbench

SBI_ARBITER -- requirements
Module: sbi_arbiter

---
 rtl/sbi_arbiter.sv | 125 ++++++++++++
 tb/tb_sbi_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbi_arbiter.sv
// Two-requester round-robin arbiter driving an SBI burst master port.
// Each burst runs IDLE -> START (address phase) -> BURST (len+1 beats).
module sbi_arbiter #(
    parameter int Width = 32,
    parameter int Aw    = 8,
    parameter int LenW  = 8
) (
    input  logic                   bCLK,
    input  logic                   bRSTn,
    input  logic [1:0]             req_i,
    input  logic [1:0][Aw-1:0]     addr_i,
    input  logic [1:0]             write_i,
    input  logic [1:0][LenW-1:0]   len_i,
    input  logic [1:0][Width-1:0]  wdata_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             ack_o,
    output logic [1:0]             done_o,
    output logic [1:0]             rvalid_o,
    output logic [Width-1:0]       rdata_o,
    output logic [Aw-1:0]          bADDR,
    output logic                   bSTART,
    output logic                   bACCESS,
    output logic                   bWRITE,
    output logic [Width-1:0]       bD,
    input  logic [Width-1:0]       bQ,
    input  logic                   bVALID
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BURST
    } state_t;

    state_t          state, state_nx;
    logic            owner, owner_d, ptr, winner, take, last;
    logic [Aw-1:0]   lat_addr;
    logic            lat_write;
    logic [LenW-1:0] lat_len;
    logic [LenW-1:0] cnt;

    // Pointer only matters when both request; a lone requester always wins.
    always_comb begin
        unique case (req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ptr;
        endcase
    end

    assign last = (cnt == lat_len);

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        gnt_o    = '0;
        ack_o    = '0;
        done_o   = '0;
        bSTART   = 1'b0;
        bACCESS  = 1'b0;
        bWRITE   = 1'b0;
        bADDR    = '0;
        bD       = '0;
        unique case (state)
            IDLE: begin
                // gnt is combinational from req, so it is masked while reset is held
                if (bRSTn && (|req_i)) begin
                    take          = 1'b1;
                    gnt_o[winner] = 1'b1;
                    state_nx      = START;
                end
            end
            START: begin
                bSTART   = 1'b1;
                bADDR    = lat_addr;
                bWRITE   = lat_write;
                state_nx = BURST;
            end
            BURST: begin
                bACCESS      = 1'b1;
                bWRITE       = lat_write;
                ack_o[owner] = 1'b1;
                if (lat_write) begin
                    bD = wdata_i[owner];
                end
                if (last) begin
                    done_o[owner] = 1'b1;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read data lags its beat by one cycle, so route it with the delayed owner.
    assign rvalid_o = (bRSTn && bVALID) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o  = bQ;

    always_ff @(posedge bCLK or negedge bRSTn) begin
        if (!bRSTn) begin
            state     <= IDLE;
            owner     <= 1'b0;
            owner_d   <= 1'b0;
            ptr       <= 1'b0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_len   <= '0;
            cnt       <= '0;
        end else begin
            state   <= state_nx;
            owner_d <= owner;
            if (take) begin
                owner     <= winner;
                ptr       <= ~winner;
                lat_addr  <= addr_i[winner];
                lat_write <= write_i[winner];
                lat_len   <= len_i[winner];
                cnt       <= '0;
            end else if (state == BURST) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sbi_arbiter.sv
// Directed bench for sbi_arbiter: expected grants, address phases, beats and
// read returns are queued at stimulus time and matched by a negedge monitor.
module tb_sbi_arbiter;

    logic              bCLK = 1'b0;
    logic              bRSTn;
    logic [1:0]        req_i, write_i;
    logic [1:0][7:0]   addr_i, len_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0]        gnt_o, ack_o, done_o, rvalid_o;
    logic [31:0]       rdata_o, bD, bQ;
    logic [7:0]        bADDR;
    logic              bSTART, bACCESS, bWRITE, bVALID;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_gnt[$];
    logic [63:0] q_start[$];
    logic [63:0] q_beat[$];
    logic [63:0] q_rv[$];
    logic [31:0] slave_q[$];
    bit          prev_gnt = 1'b0;

    sbi_arbiter #(.Width(32), .Aw(8), .LenW(8)) dut (
        .bCLK(bCLK), .bRSTn(bRSTn),
        .req_i(req_i), .addr_i(addr_i), .write_i(write_i), .len_i(len_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .done_o(done_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .bADDR(bADDR), .bSTART(bSTART), .bACCESS(bACCESS), .bWRITE(bWRITE),
        .bD(bD), .bQ(bQ), .bVALID(bVALID)
    );

    always #5 bCLK = ~bCLK;

    function automatic logic [31:0] wpat(input int k, input int j);
        return 32'hC000_0000 | 32'(k << 24) | 32'(j);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int k, input logic [7:0] a, input logic w, input int len);
        logic [1:0] oh;
        oh = (k == 1) ? 2'b10 : 2'b01;
        q_gnt.push_back(64'(oh));
        q_start.push_back(64'({a, w}));
        for (int j = 0; j <= len; j++)
            q_beat.push_back(64'({oh, (j == len) ? oh : 2'b00, w, w ? wpat(k, j) : 32'h0}));
    endtask

    task automatic push_read(input int k, input logic [31:0] d);
        slave_q.push_back(d);
        q_rv.push_back(64'({(k == 1) ? 2'b10 : 2'b01, d}));
    endtask

    task automatic sync();
        @(posedge bCLK);
        #1;
    endtask

    task automatic setup(input int k, input logic [7:0] a, input logic w, input logic [7:0] l);
        addr_i[k]  = a;
        write_i[k] = w;
        len_i[k]   = l;
        req_i[k]   = 1'b1;
    endtask

    task automatic wait_gnt(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge bCLK);
            if (gnt_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("gnt_wait", 64'(ok), 64'(1));
        sync();
        req_i[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge bCLK);
            if (done_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_wait", 64'(ok), 64'(1));
    endtask

    task automatic wait_quiet();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge bCLK);
            #1;
            if (!bSTART && !bACCESS && gnt_o == 2'b00 && q_gnt.size() == 0 &&
                q_start.size() == 0 && q_beat.size() == 0 && q_rv.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("quiet_wait", 64'(ok), 64'(1));
    endtask

    // Requester write-data model: advance one beat the cycle after each ack.
    initial begin
        int         widx[2];
        logic [1:0] a, g;
        widx[0] = 0;
        widx[1] = 0;
        wdata_i[0] = wpat(0, 0);
        wdata_i[1] = wpat(1, 0);
        forever begin
            @(negedge bCLK);
            a = ack_o;
            g = gnt_o;
            @(posedge bCLK);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (g[k]) widx[k] = 0;
                else if (a[k]) widx[k]++;
                wdata_i[k] = wpat(k, widx[k]);
            end
        end
    end

    // SBI slave: return one read word in the cycle after each read access.
    initial begin
        bit rd;
        bVALID = 1'b0;
        bQ     = '0;
        forever begin
            @(negedge bCLK);
            rd = bRSTn && bACCESS && !bWRITE;
            @(posedge bCLK);
            #1;
            if (rd) begin
                bVALID = 1'b1;
                bQ     = (slave_q.size() != 0) ? slave_q.pop_front() : 32'hDEAD_BEEF;
            end else begin
                bVALID = 1'b0;
                bQ     = '0;
            end
        end
    end

    // Monitor: pop scoreboard entries and check cycle invariants.
    initial begin
        forever begin
            @(negedge bCLK);
            if (!bRSTn) begin
                prev_gnt = 1'b0;
                continue;
            end
            chk("onehot", 64'({$onehot0(gnt_o), $onehot0(ack_o), $onehot0(done_o), $onehot0(rvalid_o)}), 64'(4'hF));
            chk("start_access_excl", 64'(bSTART & bACCESS), 64'(0));
            chk("start_after_gnt", 64'(bSTART), 64'(prev_gnt));
            if (!bSTART) chk("addr_zero", 64'(bADDR), 64'(0));
            if (!bACCESS) chk("bd_zero", 64'(bD), 64'(0));
            if (gnt_o != 2'b00) begin
                if (q_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt_o), 64'(0));
                else chk("gnt", 64'(gnt_o), q_gnt.pop_front());
            end
            if (bSTART) begin
                if (q_start.size() == 0) chk("start_unexpected", 64'({bADDR, bWRITE}), 64'(0));
                else chk("start", 64'({bADDR, bWRITE}), q_start.pop_front());
            end
            if (bACCESS) begin
                if (q_beat.size() == 0) chk("beat_unexpected", 64'({ack_o, done_o, bWRITE, bD}), 64'(0));
                else chk("beat", 64'({ack_o, done_o, bWRITE, bD}), q_beat.pop_front());
            end
            if (rvalid_o != 2'b00) begin
                if (q_rv.size() == 0) chk("rvalid_unexpected", 64'({rvalid_o, rdata_o}), 64'(0));
                else chk("rvalid", 64'({rvalid_o, rdata_o}), q_rv.pop_front());
            end
            prev_gnt = |gnt_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bRSTn   = 1'b0;
        req_i   = 2'b11;
        addr_i  = '0;
        write_i = '0;
        len_i   = '0;
        #12;
        chk("reset_outputs", 64'({gnt_o, ack_o, done_o, rvalid_o, bSTART, bACCESS, bWRITE, bADDR, bD}), 64'(0));
        req_i = 2'b00;
        @(negedge bCLK);
        bRSTn = 1'b1;

        // Simultaneous requests: 0 then 1, twice.
        for (int r = 0; r < 2; r++) begin
            push_burst(0, 8'h20, 1'b1, 0);
            push_burst(1, 8'h30, 1'b1, 0);
            sync();
            setup(0, 8'h20, 1'b1, 8'd0);
            setup(1, 8'h30, 1'b1, 8'd0);
            wait_gnt(0);
            wait_gnt(1);
            wait_quiet();
        end

        // Single 4-beat write.
        push_burst(0, 8'h10, 1'b1, 3);
        sync();
        setup(0, 8'h10, 1'b1, 8'd3);
        wait_gnt(0);
        wait_quiet();

        // Two-beat read; last rvalid lands in IDLE.
        push_burst(1, 8'h40, 1'b0, 1);
        push_read(1, 32'h0000_00A5);
        push_read(1, 32'h0000_005A);
        sync();
        setup(1, 8'h40, 1'b0, 8'd1);
        wait_gnt(1);
        wait_done(1);
        @(negedge bCLK);
        chk("read_last_rv_idle", 64'({bSTART, bACCESS, rvalid_o}), 64'({1'b0, 1'b0, 2'b10}));
        wait_quiet();

        // Maximum length burst.
        push_burst(1, 8'hF0, 1'b1, 255);
        sync();
        setup(1, 8'hF0, 1'b1, 8'hFF);
        wait_gnt(1);
        wait_quiet();

        // Requester 0 waits behind 1; requester 1 fields scrambled mid-burst.
        push_burst(1, 8'h55, 1'b1, 2);
        push_burst(0, 8'h66, 1'b1, 0);
        sync();
        setup(1, 8'h55, 1'b1, 8'd2);
        wait_gnt(1);
        addr_i[1]  = 8'hEE;
        len_i[1]   = 8'h07;
        write_i[1] = 1'b0;
        setup(0, 8'h66, 1'b1, 8'd0);
        wait_done(1);
        @(negedge bCLK);
        chk("gnt_after_done", 64'(gnt_o), 64'(2'b01));
        sync();
        req_i[0] = 1'b0;
        wait_quiet();

        // Reset on the 2nd beat of a 4-beat burst.
        q_gnt.push_back(64'(2'b01));
        q_start.push_back(64'({8'h77, 1'b1}));
        q_beat.push_back(64'({2'b01, 2'b00, 1'b1, wpat(0, 0)}));
        sync();
        setup(0, 8'h77, 1'b1, 8'd3);
        wait_gnt(0);
        @(posedge bCLK);
        @(posedge bCLK);
        #2;
        chk("second_beat_active", 64'({bACCESS, ack_o}), 64'({1'b1, 2'b01}));
        bRSTn = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({gnt_o, ack_o, done_o, rvalid_o, bSTART, bACCESS, bWRITE, bADDR, bD}), 64'(0));
        @(negedge bCLK);
        chk("reset_hold_outputs", 64'({gnt_o, ack_o, done_o, rvalid_o, bSTART, bACCESS, bWRITE, bADDR, bD}), 64'(0));
        @(negedge bCLK);
        bRSTn = 1'b1;

        // After reset the pointer favours 0 again.
        push_burst(0, 8'h81, 1'b1, 1);
        push_burst(1, 8'h82, 1'b1, 0);
        sync();
        setup(0, 8'h81, 1'b1, 8'd1);
        setup(1, 8'h82, 1'b1, 8'd0);
        wait_gnt(0);
        wait_gnt(1);
        wait_quiet();

        chk("queues_drained", 64'(q_gnt.size() + q_start.size() + q_beat.size() + q_rv.size() + slave_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
